// File: rtl/mc_controller_ext.sv
`timescale 1ns/1ps
// Multi-cycle MIPS-style main controller with branch-not-equal, jumps, immediate ALU ops,
// an illegal-encoding trap and a retired-instruction counter.
module mc_controller_ext #(
    parameter int CNT_W   = 16,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             reg_write,
    output logic             ir_write,
    output logic             l_or_d,
    output logic             alusrcA,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             ext_zero,
    output logic             mem_read,
    output logic             mem_write,
    output logic             trap,
    output logic [1:0]       reg_dst,
    output logic [1:0]       reg_wdst,
    output logic [1:0]       alusrcB,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_J      = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12,
        S_IEXE   = 4'd13,
        S_IWB    = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b000110;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;

    function automatic logic rfunc_legal(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Illegal encodings either trap or silently fall back to the next fetch.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t illegal_s;
        if (TRAP_EN) begin
            illegal_s = S_TRAP;
        end else begin
            illegal_s = S_FETCH;
        end
        case (op)
            OP_RTYPE: begin
                if (rfunc_legal(fn)) begin
                    return S_REXE;
                end else begin
                    return illegal_s;
                end
            end
            OP_LW, OP_SW:                        return S_MADDR;
            OP_BEQ:                              return S_BEQ;
            OP_BNE:                              return S_BNE;
            OP_J:                                return S_J;
            OP_JAL:                              return S_JAL;
            OP_JR:                               return S_JR;
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:  return S_IEXE;
            default:                             return illegal_s;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ADDIU: return ALU_ADD;
            OP_SLTI:  return ALU_SLT;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            default:  return ALU_AND;
        endcase
    endfunction

    // State sequencing and retirement counting; every return to FETCH except the NOP path retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_FETCH;
            count_r <= '0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: state_r <= decode_next(opcode, func);
                S_MADDR: begin
                    if (opcode == OP_LW) begin
                        state_r <= S_MRD;
                    end else begin
                        state_r <= S_MWR;
                    end
                end
                S_MRD: begin
                    if (mem_ready) begin
                        state_r <= S_MWB;
                    end
                end
                S_MWR: begin
                    if (mem_ready) begin
                        state_r <= S_FETCH;
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                S_REXE: state_r <= S_RWB;
                S_IEXE: state_r <= S_IWB;
                S_MWB, S_RWB, S_BEQ, S_BNE, S_J, S_JAL, S_JR, S_IWB: begin
                    state_r <= S_FETCH;
                    count_r <= count_r + CNT_W'(1);
                end
                S_TRAP:  state_r <= S_TRAP;
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Control outputs decoded from the present state; anything not driven by a state stays 0.
    always_comb begin
        reg_write     = 1'b0;
        ir_write      = 1'b0;
        l_or_d        = 1'b0;
        alusrcA       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        ext_zero      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        trap          = 1'b0;
        reg_dst       = 2'b00;
        reg_wdst      = 2'b00;
        alusrcB       = 2'b00;
        pc_src        = 2'b00;
        alu_op        = ALU_AND;
        case (state_r)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrcB  = 2'b01;
                alu_op   = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                alusrcB = 2'b11;
                alu_op  = ALU_ADD;
            end
            S_MADDR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                alu_op  = ALU_ADD;
            end
            S_MRD: begin
                mem_read = 1'b1;
                l_or_d   = 1'b1;
            end
            S_MWB: begin
                reg_write = 1'b1;
                reg_wdst  = 2'b01;
            end
            S_MWR: begin
                mem_write = 1'b1;
                l_or_d    = 1'b1;
            end
            S_REXE: begin
                alusrcA = 1'b1;
                alu_op  = rtype_alu(func);
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BEQ, S_BNE: begin
                alusrcA       = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b10;
                branch_ne     = (state_r == S_BNE);
            end
            S_J: begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_src    = 2'b01;
                reg_write = 1'b1;
                reg_dst   = 2'b10;
                reg_wdst  = 2'b10;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
            end
            S_IEXE: begin
                alusrcA  = 1'b1;
                alusrcB  = 2'b10;
                alu_op   = imm_alu(opcode);
                ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI);
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

    assign instr_count = count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_mc_controller_ext.sv
`timescale 1ns/1ps
// Randomized bench: two controllers (trapping/16-bit count and NOP/2-bit count) driven in lockstep
// and compared cycle by cycle against an instruction-level reference model.
module tb_mc_controller_ext;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MADDR = 4'd2, ST_MRD  = 4'd3;
    localparam logic [3:0] ST_MWB   = 4'd4,  ST_MWR    = 4'd5,  ST_REXE  = 4'd6, ST_RWB  = 4'd7;
    localparam logic [3:0] ST_BEQ   = 4'd8,  ST_BNE    = 4'd9,  ST_J     = 4'd10, ST_JAL = 4'd11;
    localparam logic [3:0] ST_JR    = 4'd12, ST_IEXE   = 4'd13, ST_IWB   = 4'd14, ST_TRAP = 4'd15;

    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000, A_OR = 3'b001, A_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write, ir_write, l_or_d, alusrcA, pc_write, pc_write_cond;
        logic       branch_ne, ext_zero, mem_read, mem_write, trap;
        logic [1:0] reg_dst, reg_wdst, alusrcB, pc_src;
        logic [2:0] alu_op;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        ctl_t       c;
        bit         retire;
    } step_t;

    logic clk = 1'b0;
    logic rst, mem_ready;
    logic [5:0] opcode, func;

    logic reg_write_a, ir_write_a, l_or_d_a, alusrcA_a, pc_write_a, pc_write_cond_a;
    logic branch_ne_a, ext_zero_a, mem_read_a, mem_write_a, trap_a;
    logic [1:0] reg_dst_a, reg_wdst_a, alusrcB_a, pc_src_a;
    logic [2:0] alu_op_a;
    logic [15:0] instr_count_a;
    logic [3:0] state_a;

    logic reg_write_b, ir_write_b, l_or_d_b, alusrcA_b, pc_write_b, pc_write_cond_b;
    logic branch_ne_b, ext_zero_b, mem_read_b, mem_write_b, trap_b;
    logic [1:0] reg_dst_b, reg_wdst_b, alusrcB_b, pc_src_b;
    logic [2:0] alu_op_b;
    logic [1:0] instr_count_b;
    logic [3:0] state_b;

    mc_controller_ext #(.CNT_W(16), .TRAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .reg_write(reg_write_a), .ir_write(ir_write_a), .l_or_d(l_or_d_a), .alusrcA(alusrcA_a),
        .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .branch_ne(branch_ne_a),
        .ext_zero(ext_zero_a), .mem_read(mem_read_a), .mem_write(mem_write_a), .trap(trap_a),
        .reg_dst(reg_dst_a), .reg_wdst(reg_wdst_a), .alusrcB(alusrcB_a), .pc_src(pc_src_a),
        .alu_op(alu_op_a), .instr_count(instr_count_a), .state(state_a)
    );

    mc_controller_ext #(.CNT_W(2), .TRAP_EN(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .reg_write(reg_write_b), .ir_write(ir_write_b), .l_or_d(l_or_d_b), .alusrcA(alusrcA_b),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .branch_ne(branch_ne_b),
        .ext_zero(ext_zero_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .trap(trap_b),
        .reg_dst(reg_dst_b), .reg_wdst(reg_wdst_b), .alusrcB(alusrcB_b), .pc_src(pc_src_b),
        .alu_op(alu_op_b), .instr_count(instr_count_b), .state(state_b)
    );

    ctl_t obs_a, obs_b;
    assign obs_a = {reg_write_a, ir_write_a, l_or_d_a, alusrcA_a, pc_write_a, pc_write_cond_a,
                    branch_ne_a, ext_zero_a, mem_read_a, mem_write_a, trap_a,
                    reg_dst_a, reg_wdst_a, alusrcB_a, pc_src_a, alu_op_a};
    assign obs_b = {reg_write_b, ir_write_b, l_or_d_b, alusrcA_b, pc_write_b, pc_write_cond_b,
                    branch_ne_b, ext_zero_b, mem_read_b, mem_write_b, trap_b,
                    reg_dst_b, reg_wdst_b, alusrcB_b, pc_src_b, alu_op_b};

    int checks = 0;
    int errors = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;
    step_t q[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [3:0] sa, input ctl_t ca, input logic [3:0] sb, input ctl_t cb);
        check("state_a", {28'd0, state_a}, {28'd0, sa});
        check("ctl_a", {10'd0, obs_a}, {10'd0, ca});
        check("count_a", {16'd0, instr_count_a}, cnt_a % 65536);
        check("state_b", {28'd0, state_b}, {28'd0, sb});
        check("ctl_b", {10'd0, obs_b}, {10'd0, cb});
        check("count_b", {30'd0, instr_count_b}, cnt_b % 4);
    endtask

    function automatic ctl_t fetch_c(input logic ready);
        ctl_t c = '0;
        c.mem_read = 1'b1;
        c.alusrcB  = 2'b01;
        c.alu_op   = A_ADD;
        c.ir_write = ready;
        c.pc_write = ready;
        return c;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return A_ADD;
            6'b100011: return A_SUB;
            6'b100100: return A_AND;
            6'b100101: return A_OR;
            default:   return A_SLT;
        endcase
    endfunction

    function automatic logic rnd_mr(input bit rmr);
        if (rmr) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic add(input logic [3:0] st, input logic mr, input ctl_t c, input bit retire);
        step_t s;
        s.st = st; s.mr = mr; s.c = c; s.retire = retire;
        q.push_back(s);
    endtask

    // Expected per-cycle trace of one legal instruction, fetch waits fw, memory waits mw.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input bit rmr);
        ctl_t c;
        for (int i = 0; i < fw; i++) add(ST_FETCH, 1'b0, fetch_c(1'b0), 1'b0);
        add(ST_FETCH, 1'b1, fetch_c(1'b1), 1'b0);
        c = '0; c.alusrcB = 2'b11; c.alu_op = A_ADD;
        add(ST_DECODE, rnd_mr(rmr), c, 1'b0);
        case (op)
            6'b000000: begin
                c = '0; c.alusrcA = 1'b1; c.alu_op = r_alu(fn);
                add(ST_REXE, rnd_mr(rmr), c, 1'b0);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01;
                add(ST_RWB, rnd_mr(rmr), c, 1'b1);
            end
            6'b100011, 6'b101011: begin
                c = '0; c.alusrcA = 1'b1; c.alusrcB = 2'b10; c.alu_op = A_ADD;
                add(ST_MADDR, rnd_mr(rmr), c, 1'b0);
                c = '0; c.l_or_d = 1'b1;
                if (op == 6'b100011) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                for (int i = 0; i < mw; i++) add(op == 6'b100011 ? ST_MRD : ST_MWR, 1'b0, c, 1'b0);
                add(op == 6'b100011 ? ST_MRD : ST_MWR, 1'b1, c, op == 6'b101011);
                if (op == 6'b100011) begin
                    c = '0; c.reg_write = 1'b1; c.reg_wdst = 2'b01;
                    add(ST_MWB, rnd_mr(rmr), c, 1'b1);
                end
            end
            6'b000100, 6'b000101: begin
                c = '0; c.alusrcA = 1'b1; c.alu_op = A_SUB; c.pc_write_cond = 1'b1; c.pc_src = 2'b10;
                c.branch_ne = (op == 6'b000101);
                add(op == 6'b000101 ? ST_BNE : ST_BEQ, rnd_mr(rmr), c, 1'b1);
            end
            6'b000010: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'b01;
                add(ST_J, rnd_mr(rmr), c, 1'b1);
            end
            6'b000011: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'b01; c.reg_write = 1'b1;
                c.reg_dst = 2'b10; c.reg_wdst = 2'b10;
                add(ST_JAL, rnd_mr(rmr), c, 1'b1);
            end
            6'b000110: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'b11;
                add(ST_JR, rnd_mr(rmr), c, 1'b1);
            end
            default: begin
                c = '0; c.alusrcA = 1'b1; c.alusrcB = 2'b10;
                c.alu_op   = (op == 6'b001001) ? A_ADD : (op == 6'b001010) ? A_SLT :
                             (op == 6'b001100) ? A_AND : A_OR;
                c.ext_zero = (op == 6'b001100) || (op == 6'b001101);
                add(ST_IEXE, rnd_mr(rmr), c, 1'b0);
                c = '0; c.reg_write = 1'b1;
                add(ST_IWB, rnd_mr(rmr), c, 1'b1);
            end
        endcase
    endtask

    task automatic play(input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            @(negedge clk);
            mem_ready = q[i].mr;
            #1;
            check_all(q[i].st, q[i].c, q[i].st, q[i].c);
            @(posedge clk);
            if (q[i].retire) begin
                cnt_a++;
                cnt_b++;
            end
        end
        q.delete();
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input bit rmr);
        opcode = op;
        func   = fn;
        build(op, fn, fw, mw, rmr);
        play(1000);
    endtask

    task automatic pick_run();
        logic [5:0] op;
        logic [5:0] fn;
        fn = 6'($urandom);
        case ($urandom_range(0, 15))
            0: begin op = 6'b000000; fn = 6'b100000; end
            1: begin op = 6'b000000; fn = 6'b100011; end
            2: begin op = 6'b000000; fn = 6'b100100; end
            3: begin op = 6'b000000; fn = 6'b100101; end
            4: begin op = 6'b000000; fn = 6'b101010; end
            5:  op = 6'b100011;
            6:  op = 6'b101011;
            7:  op = 6'b000100;
            8:  op = 6'b000101;
            9:  op = 6'b000010;
            10: op = 6'b000011;
            11: op = 6'b000110;
            12: op = 6'b001001;
            13: op = 6'b001010;
            14: op = 6'b001100;
            default: op = 6'b001101;
        endcase
        run(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    endtask

    task automatic do_reset(input logic mr);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = mr;
        @(posedge clk);
        cnt_a = 0;
        cnt_b = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_all(ST_FETCH, fetch_c(1'b0), ST_FETCH, fetch_c(1'b0));
        rst = 1'b1;
    endtask

    // Illegal encoding: trapping copy parks in TRAP, NOP copy drops back to FETCH unretired.
    task automatic illegal(input logic [5:0] op, input logic [5:0] fn);
        ctl_t t;
        ctl_t c;
        opcode = op;
        func   = fn;
        add(ST_FETCH, 1'b1, fetch_c(1'b1), 1'b0);
        c = '0; c.alusrcB = 2'b11; c.alu_op = A_ADD;
        add(ST_DECODE, 1'b1, c, 1'b0);
        play(1000);
        t = '0;
        t.trap = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check_all(ST_TRAP, t, ST_FETCH, fetch_c(1'b0));
            @(posedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        opcode = 6'd0;
        func = 6'd0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        run(6'b000000, 6'b100000, 0, 0, 1'b0);
        run(6'b100011, 6'd0, 0, 3, 1'b0);
        run(6'b000101, 6'd0, 1, 0, 1'b1);
        run(6'b001101, 6'd0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) run(6'b000010, 6'($urandom), $urandom_range(0, 2), 0, 1'b1);
        for (int i = 0; i < 40; i++) pick_run();

        opcode = 6'b101011;
        func   = 6'd0;
        build(6'b101011, 6'd0, 0, 6, 1'b1);
        play(5);
        do_reset(1'b1);

        illegal(6'b111111, 6'd0);
        do_reset(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) pick_run();
        illegal(6'b000000, 6'b000000);
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) pick_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
